// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared definitions for the HI/LO multiply-divide unit.
//   - md_op_e   : MD operation encodings (MULT..MTLO; 6-7 reserved)
//   - md_state_e: sequencing FSM states
//   - default busy latencies and the countdown width
// Optional feature macro used by the unit: MD_CANCEL_EN.
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_OP_MULT  = 3'd0,
    MD_OP_MULTU = 3'd1,
    MD_OP_DIV   = 3'd2,
    MD_OP_DIVU  = 3'd3,
    MD_OP_MTHI  = 3'd4,
    MD_OP_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/md_unit_if.sv
// md_unit_if: issue/result bundle between the E stage and md_unit.
//   start, md_op, a, b : issue side (driven by master)
//   cancel             : flush of an in-flight op (only with MD_CANCEL_EN)
//   busy, hi, lo       : unit status and architectural HI/LO (driven by slave)
interface md_unit_if;
  logic        start;
  logic [2:0]  md_op;
`ifdef MD_CANCEL_EN
  logic        cancel;
`endif
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

`ifdef MD_CANCEL_EN
  modport master (output start, md_op, cancel, a, b, input busy, hi, lo);
  modport slave  (input start, md_op, cancel, a, b, output busy, hi, lo);
`else
  modport master (output start, md_op, a, b, input busy, hi, lo);
  modport slave  (input start, md_op, a, b, output busy, hi, lo);
`endif
endinterface

// File: rtl/md_arith.sv
// md_arith: combinational MULT/MULTU/DIV/DIVU datapath.
//   md_op_i  : operation code
//   a_i, b_i : rs / rt operands
//   result_o : {hi, lo} result ({remainder, quotient} for divides)
//   wr_o     : result may be committed (0 for divide-by-zero, MT*, reserved)
module md_arith
  import md_unit_pkg::*;
(
  input  logic [2:0]  md_op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] result_o,
  output logic        wr_o
);

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, q_s, r_s;
  logic        a_neg, b_neg;

  always_comb begin
    prod_s = 64'($signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i}));
    prod_u = {32'd0, a_i} * {32'd0, b_i};

    // Signed divide on magnitudes, then restore signs: quotient truncates toward
    // zero, remainder follows the dividend. 0x80000000 / -1 wraps to 0x80000000.
    a_neg = a_i[31];
    b_neg = b_i[31];
    a_mag = a_neg ? -a_i : a_i;
    b_mag = b_neg ? -b_i : b_i;
    q_mag = a_mag / b_mag;
    r_mag = a_mag % b_mag;
    q_s   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    r_s   = a_neg ? -r_mag : r_mag;

    result_o = '0;
    wr_o     = 1'b0;
    case (md_op_i)
      MD_OP_MULT:  begin result_o = prod_s; wr_o = 1'b1; end
      MD_OP_MULTU: begin result_o = prod_u; wr_o = 1'b1; end
      MD_OP_DIV:   begin result_o = {r_s, q_s}; wr_o = (b_i != '0); end
      MD_OP_DIVU:  begin result_o = {a_i % b_i, a_i / b_i}; wr_o = (b_i != '0); end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: HI/LO multiply-divide unit with fixed-latency countdown.
//   clk, reset : clock, asynchronous active-high reset
//   md_bus     : md_unit_if.slave (start/md_op/a/b in, busy/hi/lo out,
//                plus cancel when MD_CANCEL_EN is defined)
// Result is computed at issue, staged, and committed to HI/LO on the edge
// where the countdown reaches zero. MTHI/MTLO write in one cycle.
// Optional: MD_CANCEL_EN adds cancel, which aborts RUN or suppresses a start.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic      clk,
  input  logic      reset,
  md_unit_if.slave  md_bus
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      hin_q, hin_d, lon_q, lon_d;
  logic             wrn_q, wrn_d;

  logic [63:0]      res;
  logic             res_wr;
  logic             start_ok;
  logic             cancel;

  md_arith u_arith (
    .md_op_i  (md_bus.md_op),
    .a_i      (md_bus.a),
    .b_i      (md_bus.b),
    .result_o (res),
    .wr_o     (res_wr)
  );

`ifdef MD_CANCEL_EN
  assign cancel = md_bus.cancel;
`else
  assign cancel = 1'b0;
`endif

  assign start_ok = md_bus.start && !cancel;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hin_d   = hin_q;
    lon_d   = lon_q;
    wrn_d   = wrn_q;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          case (md_bus.md_op)
            MD_OP_MULT, MD_OP_MULTU, MD_OP_DIV, MD_OP_DIVU: begin
              hin_d   = res[63:32];
              lon_d   = res[31:0];
              wrn_d   = res_wr;
              cnt_d   = md_bus.md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
              state_d = ST_RUN;
            end
            MD_OP_MTHI: hi_d = md_bus.a;
            MD_OP_MTLO: lo_d = md_bus.a;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          if (wrn_q) begin
            hi_d = hin_q;
            lo_d = lon_q;
          end
          state_d = ST_IDLE;
        end
        // Cancel overrides the commit that may be due on this same edge.
        if (cancel) begin
          cnt_d   = '0;
          hi_d    = hi_q;
          lo_d    = lo_q;
          hin_d   = '0;
          lon_d   = '0;
          wrn_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      hin_q   <= '0;
      lon_q   <= '0;
      wrn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hin_q   <= hin_d;
      lon_q   <= lon_d;
      wrn_q   <= wrn_d;
    end
  end

  assign md_bus.busy = (state_q == ST_RUN);
  assign md_bus.hi   = hi_q;
  assign md_bus.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
  import md_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_unit_if bus ();

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
    .clk    (clk),
    .reset  (reset),
    .md_bus (bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned cyc;
    string       tag;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned cyc;
    string       tag;
  } exp_t;

  exp_t sb[$];
  vec_t vt[13];
  int   total = 0;
  int   bad   = 0;
  logic [31:0] model_hi, model_lo;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.md_op = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
  endtask

  // Counts busy cycles (bounded) and tracks whether HI/LO held their prior
  // architectural value until busy fell.
  task automatic wait_done(input logic [31:0] ph, input logic [31:0] pl,
                           output int unsigned n, output logic held);
    n    = 0;
    held = 1'b1;
    while (bus.busy === 1'b1 && n < 64) begin
      if (bus.hi !== ph || bus.lo !== pl) held = 1'b0;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic complete(input int unsigned n, input logic held);
    exp_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    check32({e.tag, "_cycles"}, 32'(n), 32'(e.cyc));
    check32({e.tag, "_hi"}, bus.hi, e.hi);
    check32({e.tag, "_lo"}, bus.lo, e.lo);
    check32({e.tag, "_busy_end"}, {31'd0, bus.busy}, 32'd0);
    if (e.cyc > 0) check32({e.tag, "_hold"}, {31'd0, held}, 32'd1);
    model_hi = e.hi;
    model_lo = e.lo;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el,
                        input int unsigned cyc, input string tag);
    int unsigned n;
    logic held;
    sb.push_back('{eh, el, cyc, tag});
    issue(op, a, b);
    wait_done(model_hi, model_lo, n, held);
    complete(n, held);
  endtask

  initial begin
    int unsigned n;
    logic held;

    vt[0]  = '{3'd4, 32'h11,       32'h0,        32'h11,       32'h0,        0,  "mthi"};
    vt[1]  = '{3'd5, 32'h22,       32'h0,        32'h11,       32'h22,       0,  "mtlo"};
    vt[2]  = '{3'd2, 32'h5,        32'h0,        32'h11,       32'h22,       10, "div_by0"};
    vt[3]  = '{3'd0, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5,  "mult"};
    vt[4]  = '{3'd1, 32'hFFFFFFFE, 32'h3,        32'h00000002, 32'hFFFFFFFA, 5,  "multu"};
    vt[5]  = '{3'd2, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div_neg"};
    vt[6]  = '{3'd3, 32'h7,        32'h2,        32'h1,        32'h3,        10, "divu"};
    vt[7]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 10, "div_ovf"};
    vt[8]  = '{3'd2, 32'h7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 10, "div_negb"};
    vt[9]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5,  "multu_max"};
    vt[10] = '{3'd6, 32'h123,      32'h4,        32'hFFFFFFFE, 32'h00000001, 0,  "reserved"};
    vt[11] = '{3'd3, 32'h9,        32'h0,        32'hFFFFFFFE, 32'h00000001, 10, "divu_by0"};
    vt[12] = '{3'd0, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 5,  "mult_ext"};

    bus.start = 1'b0;
    bus.md_op = '0;
    bus.a     = '0;
    bus.b     = '0;
`ifdef MD_CANCEL_EN
    bus.cancel = 1'b0;
`endif
    model_hi = '0;
    model_lo = '0;
    reset = 1'b1;
    #12;
    check32("reset_hi", bus.hi, 32'h0);
    check32("reset_lo", bus.lo, 32'h0);
    check32("reset_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 13; i++)
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, vt[i].cyc, vt[i].tag);

    // Start during busy (MTHI 0xDEAD) must be ignored.
    sb.push_back('{32'h0, 32'hC, 5, "ignore"});
    issue(3'd0, 32'h3, 32'h4);
    bus.start = 1'b1;
    bus.md_op = 3'd4;
    bus.a     = 32'hDEAD;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = '0;
    wait_done(model_hi, model_lo, n, held);
    complete(n + 1, held);
    total++;
    if (bus.hi === 32'hDEAD) begin
      bad++;
      $display("FAIL ignore_not_dead: got 0x%08h expected not 0x0000dead", bus.hi);
    end

    // Reset asserted mid-RUN clears immediately and discards the pending result.
    run_op(3'd4, 32'h55, 32'h0, 32'h55, 32'hC, 0, "pre_rst");
    issue(3'd2, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check32("rst_mid_hi", bus.hi, 32'h0);
    check32("rst_mid_lo", bus.lo, 32'h0);
    check32("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_hi = '0;
    model_lo = '0;
    repeat (15) @(negedge clk);
    check32("rst_nocommit_hi", bus.hi, 32'h0);
    check32("rst_nocommit_lo", bus.lo, 32'h0);
    check32("rst_nocommit_busy", {31'd0, bus.busy}, 32'd0);

`ifdef MD_CANCEL_EN
    run_op(3'd4, 32'hA1, 32'h0, 32'hA1, 32'h0, 0, "cpre_hi");
    run_op(3'd5, 32'hB2, 32'h0, 32'hA1, 32'hB2, 0, "cpre_lo");
    issue(3'd2, 32'd9, 32'd2);
    repeat (3) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check32("cancel_busy", {31'd0, bus.busy}, 32'd0);
    check32("cancel_hi", bus.hi, 32'hA1);
    check32("cancel_lo", bus.lo, 32'hB2);
    repeat (15) @(negedge clk);
    check32("cancel_late_hi", bus.hi, 32'hA1);
    check32("cancel_late_lo", bus.lo, 32'hB2);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.md_op  = 3'd5;
    bus.a      = 32'h77;
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    check32("cancel_start_busy", {31'd0, bus.busy}, 32'd0);
    check32("cancel_start_lo", bus.lo, 32'hB2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
HI/LO multiply-divide unit that executes MULT/MULTU/DIV/DIVU and MTHI/MTLO, and supplies the HI/LO values that MFHI/MFLO read back through the write-back path.
- Sits in the E stage beside the ALU.
- Its busy output feeds the stall logic so that later MD-class instructions and MFHI/MFLO wait until the operation completes.
- Uses a fixed-latency countdown model with staged results.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (range 1..15)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (range 1..15)

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  issue pulse for the operation on md_op; sampled only when busy=0
md_op  input  3  operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved
a  input  32  rs operand; dividend / multiplicand; source for MTHI/MTLO
b  input  32  rt operand; divisor / multiplier
busy  output  1  high while a MULT/DIV operation is in flight
hi  output  32  architectural HI register
lo  output  32  architectural LO register

Behaviour:
- Reset (asynchronous, active-high): hi=0, lo=0, busy=0, countdown=0, staged results cleared. Reset mid-operation discards the pending result.
- States: IDLE, RUN.
- IDLE with start=1 and md_op in {0..3}:
  - The full result is computed combinationally from a and b.
  - The result is latched into staging registers hi_n/lo_n.
  - countdown loads MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy goes 1 on the next edge.
- RUN:
  - countdown decrements each cycle.
  - On the edge where countdown goes 1→0: hi<=hi_n, lo<=lo_n, busy<=0, return to IDLE.
  - busy is high for exactly N cycles; the result is visible on hi/lo in the cycle busy falls.
- MTHI/MTLO: in IDLE with start=1, md_op=4 writes hi<=a; md_op=5 writes lo<=a. Single-cycle, busy stays 0.
- start while busy=1: ignored entirely, no state change. The stall unit is responsible for not issuing it.
- Reserved md_op with start=1: no effect.
- Arithmetic:
  - MULT: signed 32x32→64.
  - MULTU: unsigned 32x32→64.
  - For both: {hi,lo}=product.
  - DIV: signed division, truncating toward zero; lo=quotient, hi=remainder; remainder sign follows the dividend.
  - DIVU: unsigned division; lo=quotient, hi=remainder.
  - 0x80000000 / 0xFFFFFFFF (DIV): lo=0x80000000, hi=0.
  - b=0 (DIV/DIVU): the unit still goes busy for DIV_CYCLES; hi/lo are left unchanged at completion.
- hi/lo are registered outputs, stable in all cycles except the commit/write edge.

Optional Feature:
Macro: MD_CANCEL_EN.
- Defined:
  - Adds input port cancel (1 bit), placed after md_op.
  - cancel=1 in RUN: countdown<=0, busy<=0, staging discarded, hi/lo unchanged. Used when an exception flushes the issuing instruction.
  - cancel=1 on the same edge as start in IDLE: the start is suppressed.
  - cancel has priority over a commit on the same edge.
- Not defined: the port is absent and operations always complete.

Decomposition:
- Shared package/header, alongside the existing opcode defines:
  - MD_OP_* encodings 0..5.
  - Default MULT_CYCLES/DIV_CYCLES constants.
  - Countdown width constant (4).
- Sub-module md_arith (combinational, 64-bit result from md_op, a, b, including the signed/zero-divisor rules) keeps the datapath separate from the sequencing FSM.
- Stall coupling stays in the hazard unit; it is not part of this block.

Test Plan:
- Reset: assert reset mid-RUN → hi=lo=0 and busy=0 immediately, without waiting for a clock edge; no later commit occurs.
- MULT, a=0xFFFFFFFE (-2), b=3:
  - busy high for exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - MULTU with the same operands: hi=0x00000002, lo=0xFFFFFFFA.
- DIV, a=0xFFFFFFF9 (-7), b=2:
  - After 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 7/2: lo=3, hi=1.
- DIV with b=0 and hi/lo preloaded via MTHI 0x11 and MTLO 0x22 → busy for 10 cycles, then hi=0x11 and lo=0x22 unchanged. Also DIV 0x80000000 / -1 → lo=0x80000000, hi=0.
- Issue a MULT, then while busy pulse start with MTHI a=0xDEAD → ignored; the MULT result commits correctly and hi≠0xDEAD.
- With MD_CANCEL_EN defined, start DIV, then pulse cancel in busy cycle 4 → busy drops on the next edge and hi/lo keep their prior values.
